// File: rtl/serial_sum_collector_if.sv
// Valid/ready word bus between the collector and its consumer.
// The master drives data/valid; the slave returns ready.
interface serial_sum_collector_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Serial MSB-first frame deserializer feeding a small word FIFO.
// Optional guard-bit check after the LSB: define FRAME_CHECK_EN.
module serial_sum_collector #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ser_i,
  serial_sum_collector_if.master m,
  output logic busy,
  output logic overflow,
  output logic frame_err
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef FRAME_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE, S_CAPTURE, S_GUARD
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_CAPTURE
  } state_t;
`endif

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_shift, w_shift_nx;
  logic [WIDTH-1:0] w_word, w_push_data;
  logic             w_push, w_pop;
  logic             w_full, w_wr;
  logic             w_err_nx;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow, r_frame_err;

  assign w_word = {r_shift[WIDTH-2:0], ser_i};

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_shift_nx  = r_shift;
    w_push      = 1'b0;
    w_push_data = w_word;
    w_err_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (en_i) begin
          w_shift_nx = {{(WIDTH-1){1'b0}}, ser_i};
          w_cnt_nx   = CW'(1);
          w_state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_shift_nx = w_word;
        w_cnt_nx   = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_cnt_nx = '0;
`ifdef FRAME_CHECK_EN
          w_state_nx = S_GUARD;
`else
          w_push     = 1'b1;
          w_state_nx = S_IDLE;
`endif
        end
      end
`ifdef FRAME_CHECK_EN
      // Upstream idles the line high, so a 0 here means a broken frame.
      S_GUARD: begin
        w_state_nx  = S_IDLE;
        w_push_data = r_shift;
        if (ser_i) w_push   = 1'b1;
        else       w_err_nx = 1'b1;
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
    end
  end

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = (r_count != '0) && m.m_ready;
  // A pop on the same edge frees the slot for a push into a full FIFO.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

`ifdef FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_err_nx;
  end
`else
  assign r_frame_err = 1'b0;
`endif

  assign m.m_data  = r_mem[r_rd_ptr];
  assign m.m_valid = (r_count != '0);
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
endmodule
